// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece command path: command opcodes,
// PS/2 scancodes, scheduler state encodings and FIFO sizing helper.
package tetris_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LEFT    = 3'd1,
    OP_RIGHT   = 3'd2,
    OP_ROTATE  = 3'd3,
    OP_SOFT    = 3'd4,
    OP_DROP    = 3'd5,
    OP_GRAVITY = 3'd6
  } cmd_op_e;

  // Which source produced the most recently issued command.
  typedef enum logic {
    SRC_KEY  = 1'b0,
    SRC_GRAV = 1'b1
  } src_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } issue_state_e;

  // Prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Plain (non-extended) key codes
  localparam logic [7:0] SC_A = 8'h1C;  // left
  localparam logic [7:0] SC_D = 8'h23;  // right
  localparam logic [7:0] SC_W = 8'h1D;  // rotate
  localparam logic [7:0] SC_S = 8'h1B;  // soft drop
  localparam logic [7:0] SC_Z = 8'h1A;  // hard drop
  localparam logic [7:0] SC_P = 8'h4D;  // pause (only with PAUSE_KEY_EN)

  // Extended (E0-prefixed) arrow key codes
  localparam logic [7:0] SC_ARR_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARR_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARR_UP    = 8'h75;
  localparam logic [7:0] SC_ARR_DOWN  = 8'h72;

  // Read/write pointer width for a FIFO of the given depth.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/scan_decode.sv
// PS/2 make-code decoder: tracks E0/F0 prefixes and turns the first
// non-prefix byte into a one-cycle command pulse.
// Optional PAUSE_KEY_EN: scancode 4D (non-extended) toggles the pause state,
// and while paused every other decoded command is discarded.
module scan_decode
  import tetris_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       ps2_rec,
  input  logic [7:0] scancode,
  output logic       dec_valid,
  output logic [2:0] dec_op,
  output logic       paused
);

  logic    ext_q;
  logic    brk_q;
  logic    dec_valid_q;
  cmd_op_e dec_op_q;
  cmd_op_e map_op;

  // Map the current byte under the current extended flag; OP_NOP means unmapped.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    map_op = OP_NOP;
    if (ext_q) begin
      case (scancode)
        SC_ARR_LEFT:  map_op = OP_LEFT;
        SC_ARR_RIGHT: map_op = OP_RIGHT;
        SC_ARR_UP:    map_op = OP_ROTATE;
        SC_ARR_DOWN:  map_op = OP_SOFT;
        default:      map_op = OP_NOP;
      endcase
    end else begin
      case (scancode)
        SC_A:    map_op = OP_LEFT;
        SC_D:    map_op = OP_RIGHT;
        SC_W:    map_op = OP_ROTATE;
        SC_S:    map_op = OP_SOFT;
        SC_Z:    map_op = OP_DROP;
        default: map_op = OP_NOP;
      endcase
    end
  end

  // Track prefixes and register at most one decoded command per byte.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_op_q    <= OP_NOP;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block overrides it for this edge.
      dec_valid_q <= 1'b0;
      if (ps2_rec) begin
        if (scancode == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (scancode == SC_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (!brk_q && !paused && (map_op != OP_NOP)) begin
            dec_valid_q <= 1'b1;
            dec_op_q    <= map_op;
          end
        end
      end
    end
  end

  assign dec_valid = dec_valid_q;
  assign dec_op    = dec_op_q;

`ifdef PAUSE_KEY_EN
  logic pause_hit;
  logic paused_q;

  assign pause_hit = ps2_rec && !ext_q && !brk_q && (scancode == SC_P);

  // A P make code flips the pause state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      paused_q <= 1'b0;
    end else if (pause_hit) begin
      paused_q <= ~paused_q;
    end
  end

  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

endmodule

// File: rtl/piece_cmd_scheduler.sv
// Command scheduler for the falling-piece FSM: decodes key presses into a
// small FIFO, generates gravity ticks, and issues one command at a time over
// valid/ready with round-robin between keys and gravity. Everything is
// flushed while the piece is locked.
// Optional PAUSE_KEY_EN: P key pauses gravity and issue (see scan_decode).
module piece_cmd_scheduler
  import tetris_pkg::*;
#(
  parameter int GRAV_DIV  = 25000000,
  parameter int CMD_DEPTH = 4
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       ps2_rec,
  input  logic [7:0]                 scancode,
  input  logic                       is_locked,
  input  logic                       cmd_ready,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_op,
  output logic [$clog2(CMD_DEPTH):0] q_count,
  output logic                       overflow,
  output logic                       paused
);

  localparam int            PW         = ptr_width(CMD_DEPTH);
  localparam int            CW         = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic [CW-1:0] GRAV_LAST  = CW'(GRAV_DIV - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(CMD_DEPTH);

  logic          dec_valid;
  logic [2:0]    dec_op;

  logic [2:0]    fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q;

  logic [CW-1:0] grav_cnt_q;
  logic          grav_pend_q;
  logic          grav_term;

  issue_state_e  state_q;
  src_e          last_src_q;
  logic          cmd_valid_q;
  logic [2:0]    cmd_op_q;

  logic enq_req, fifo_full, push_ok, key_rdy;
  logic can_issue, pick_key, issue_key, issue_grav;

  scan_decode u_scan_decode (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .ps2_rec   (ps2_rec),
    .scancode  (scancode),
    .dec_valid (dec_valid),
    .dec_op    (dec_op),
    .paused    (paused)
  );

  // Decoded commands are dropped while locked; a full FIFO still accepts
  // a push in the same cycle an entry is popped.
  assign enq_req   = dec_valid && !is_locked;
  assign fifo_full = (count_q == FULL_COUNT);
  assign push_ok   = enq_req && (!fifo_full || issue_key);
  assign key_rdy   = (count_q != '0);

  // Round-robin: on a tie, take the source that did not issue last.
  assign can_issue  = (state_q == ST_IDLE) && !is_locked && !paused && (key_rdy || grav_pend_q);
  assign pick_key   = key_rdy && (!grav_pend_q || (last_src_q == SRC_GRAV));
  assign issue_key  = can_issue && pick_key;
  assign issue_grav = can_issue && !pick_key;

  assign grav_term  = (grav_cnt_q == GRAV_LAST);

  // Next FIFO occupancy.
  always_comb begin
    count_d = count_q;
    if (is_locked) begin
      count_d = '0;
    end else if (push_ok && !issue_key) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && issue_key) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (is_locked) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok)   wr_ptr_q <= wr_ptr_q + 1'b1;
        if (issue_key) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (enq_req && !push_ok) overflow_q <= 1'b1;
    end
  end

  // FIFO storage write port.
  // NOTE: storage has no reset; only entries counted by count_q are ever read.
  always_ff @(posedge Clock) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= dec_op;
  end

  // Gravity divider; a terminal count while a tick is pending merges into it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
    end else if (is_locked) begin
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
    end else if (!paused) begin
      grav_cnt_q <= grav_term ? '0 : grav_cnt_q + 1'b1;
      if (grav_term) begin
        grav_pend_q <= 1'b1;
      end else if (issue_grav) begin
        grav_pend_q <= 1'b0;
      end
    end
  end

  // Issue FSM: load one command, hold it until accepted, then rest one cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      last_src_q  <= SRC_GRAV;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NOP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (can_issue) begin
            state_q     <= ST_PRESENT;
            cmd_valid_q <= 1'b1;
            if (pick_key) begin
              cmd_op_q   <= fifo_mem[rd_ptr_q];
              last_src_q <= SRC_KEY;
            end else begin
              cmd_op_q   <= OP_GRAVITY;
              last_src_q <= SRC_GRAV;
            end
          end
        end
        ST_PRESENT: begin
          if (cmd_ready) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_NOP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign q_count   = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_piece_cmd_scheduler.sv
// Self-checking bench for piece_cmd_scheduler (GRAV_DIV=16, CMD_DEPTH=4).
// Key-decode table through a scoreboard, plus hand sequences for gravity
// timing, overflow/hold, round-robin, lock, pause key and async reset.
module tb_piece_cmd_scheduler;

  localparam int GRAV_DIV  = 16;
  localparam int CMD_DEPTH = 4;

  // Expected opcode values
  localparam logic [2:0] E_NOP    = 3'd0;
  localparam logic [2:0] E_LEFT   = 3'd1;
  localparam logic [2:0] E_RIGHT  = 3'd2;
  localparam logic [2:0] E_ROTATE = 3'd3;
  localparam logic [2:0] E_SOFT   = 3'd4;
  localparam logic [2:0] E_DROP   = 3'd5;
  localparam logic [2:0] E_GRAV   = 3'd6;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       ps2_rec;
  logic [7:0] scancode;
  logic       is_locked;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [2:0] q_count;
  logic       overflow;
  logic       paused;

  piece_cmd_scheduler #(
    .GRAV_DIV  (GRAV_DIV),
    .CMD_DEPTH (CMD_DEPTH)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .ps2_rec   (ps2_rec),
    .scancode  (scancode),
    .is_locked (is_locked),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .q_count   (q_count),
    .overflow  (overflow),
    .paused    (paused)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Scoreboard of expected key commands; gravity is measured separately.
  logic [2:0] exp_q [$];
  bit         sb_on = 1'b0;

  always @(negedge Clock) begin
    if (sb_on && Resetn && cmd_valid && cmd_ready && (cmd_op != E_GRAV)) begin
      if (exp_q.size() == 0) check("sb_unexpected_cmd", int'(cmd_op), int'(E_NOP));
      else                   check("sb_cmd_order", int'(cmd_op), int'(exp_q.pop_front()));
    end
  end

  // Entry and exit at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    ps2_rec  = 1'b1;
    scancode = b;
    @(negedge Clock);
    ps2_rec  = 1'b0;
    scancode = 8'h00;
    @(negedge Clock);
  endtask

  // Wait (bounded) for a handshake; returns one falling edge past it.
  task automatic wait_hs(input int budget, output logic [2:0] op, output int at, output bit ok);
    ok = 1'b0;
    op = E_NOP;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      if (cmd_valid && cmd_ready) begin
        op = cmd_op;
        at = cyc;
        ok = 1'b1;
        @(negedge Clock);
        return;
      end
      @(negedge Clock);
    end
  endtask

  typedef struct packed {
    logic [1:0] n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [2:0] exp_op;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] op;
    logic [7:0] bytes [3];
    logic [2:0] rest_ops [3];
    int         at, at_prev, c0, nk, bad;
    bit         ok;

    vecs[0]  = '{2'd1, 8'h1A, 8'h00, 8'h00, E_DROP};
    vecs[1]  = '{2'd2, 8'hF0, 8'h1A, 8'h00, E_NOP};
    vecs[2]  = '{2'd2, 8'hE0, 8'h6B, 8'h00, E_LEFT};
    vecs[3]  = '{2'd2, 8'hE0, 8'h74, 8'h00, E_RIGHT};
    vecs[4]  = '{2'd3, 8'hE0, 8'hF0, 8'h74, E_NOP};
    vecs[5]  = '{2'd1, 8'h1C, 8'h00, 8'h00, E_LEFT};
    vecs[6]  = '{2'd1, 8'h23, 8'h00, 8'h00, E_RIGHT};
    vecs[7]  = '{2'd1, 8'h1D, 8'h00, 8'h00, E_ROTATE};
    vecs[8]  = '{2'd1, 8'h1B, 8'h00, 8'h00, E_SOFT};
    vecs[9]  = '{2'd2, 8'hE0, 8'h75, 8'h00, E_ROTATE};
    vecs[10] = '{2'd2, 8'hE0, 8'h72, 8'h00, E_SOFT};
    vecs[11] = '{2'd2, 8'h4D, 8'h4D, 8'h00, E_NOP};
    vecs[12] = '{2'd1, 8'h29, 8'h00, 8'h00, E_NOP};
    vecs[13] = '{2'd2, 8'hE0, 8'h1A, 8'h00, E_NOP};
    vecs[14] = '{2'd3, 8'hF0, 8'hE0, 8'h6B, E_NOP};

    rest_ops[0] = E_ROTATE;
    rest_ops[1] = E_SOFT;
    rest_ops[2] = E_DROP;

    Resetn    = 1'b0;
    ps2_rec   = 1'b0;
    scancode  = 8'h00;
    is_locked = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(negedge Clock);

    // Reset values
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_op",    cmd_op,    0);
    check("rst_q_count",   q_count,   0);
    check("rst_overflow",  overflow,  0);
    check("rst_paused",    paused,    0);

    // Gravity only: first tick 17 cycles after release, then every 16
    c0     = cyc;
    Resetn = 1'b1;
    wait_hs(40, op, at, ok);
    check("grav_first_seen", ok, 1);
    check("grav_first_op",   op, E_GRAV);
    check("grav_first_time", at - c0, GRAV_DIV + 1);
    at_prev = at;
    for (int k = 0; k < 2; k++) begin
      wait_hs(40, op, at, ok);
      check($sformatf("grav%0d_op", k),     op, E_GRAV);
      check($sformatf("grav%0d_period", k), at - at_prev, GRAV_DIV);
      at_prev = at;
    end
    check("grav_q_count", q_count, 0);

    // Decode table through the scoreboard
    sb_on = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      bytes[0] = vecs[i].b0;
      bytes[1] = vecs[i].b1;
      bytes[2] = vecs[i].b2;
      if (vecs[i].exp_op != E_NOP) exp_q.push_back(vecs[i].exp_op);
      for (int j = 0; j < int'(vecs[i].n); j++) send_byte(bytes[j]);
      repeat (8) @(negedge Clock);
      check($sformatf("vec%0d_q_count", i), q_count, 0);
      check($sformatf("vec%0d_sb_left", i), exp_q.size(), 0);
    end
    sb_on = 1'b0;
    check("vec_overflow_clear", overflow, 0);

    // Overflow and hold: sync to a gravity tick, then 6 keys with ready low
    wait_hs(40, op, at, ok);
    check("ovf_sync_op", op, E_GRAV);
    cmd_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h23);
    send_byte(8'h1D);
    send_byte(8'h1B);
    send_byte(8'h1A);
    send_byte(8'h1C);
    repeat (2) @(negedge Clock);
    check("ovf_q_count", q_count,   4);
    check("ovf_flag",    overflow,  1);
    check("ovf_valid",   cmd_valid, 1);
    check("ovf_op",      cmd_op,    E_LEFT);
    bad = 0;
    repeat (40) begin
      @(negedge Clock);
      if (!(cmd_valid && (cmd_op == E_LEFT))) bad++;
    end
    check("hold_stable_cycles_bad", bad, 0);

    // Round-robin with gravity pending: key, GRAVITY, key at 2-cycle spacing
    cmd_ready = 1'b1;
    wait_hs(4, op, at, ok);
    check("rr_first_op", op, E_LEFT);
    at_prev = at;
    wait_hs(4, op, at, ok);
    check("rr_second_op", op, E_GRAV);
    check("rr_gap1", at - at_prev, 2);
    at_prev = at;
    wait_hs(4, op, at, ok);
    check("rr_third_op", op, E_RIGHT);
    check("rr_gap2", at - at_prev, 2);
    nk = 0;
    for (int k = 0; k < 8; k++) begin
      if (nk < 3) begin
        wait_hs(40, op, at, ok);
        if (ok && (op != E_GRAV)) begin
          check($sformatf("rr_key%0d", nk), op, rest_ops[nk]);
          nk++;
        end
      end
    end
    check("rr_keys_seen", nk, 3);
    check("rr_q_count", q_count, 0);

    // Lock: brief pulse restarts gravity, then 4 keys with ready low
    is_locked = 1'b1;
    repeat (2) @(negedge Clock);
    is_locked = 1'b0;
    cmd_ready = 1'b0;
    send_byte(8'h1D);
    send_byte(8'h1B);
    send_byte(8'h1A);
    send_byte(8'h1C);
    @(negedge Clock);
    check("lk_pre_valid", cmd_valid, 1);
    check("lk_pre_op",    cmd_op,    E_ROTATE);
    check("lk_pre_q",     q_count,   3);
    is_locked = 1'b1;
    @(negedge Clock);
    check("lk_flush_q",   q_count,   0);
    check("lk_hold_valid", cmd_valid, 1);
    check("lk_hold_op",   cmd_op,    E_ROTATE);
    send_byte(8'h1C);
    @(negedge Clock);
    check("lk_discard_q", q_count, 0);
    cmd_ready = 1'b1;
    wait_hs(4, op, at, ok);
    check("lk_complete_op", op, E_ROTATE);
    wait_hs(40, op, at, ok);
    check("lk_no_issue", ok, 0);
    check("ovf_sticky", overflow, 1);
    at_prev   = cyc;
    is_locked = 1'b0;
    wait_hs(40, op, at, ok);
    check("unlock_grav_op",   op, E_GRAV);
    check("unlock_grav_time", at - at_prev, GRAV_DIV + 1);

`ifdef PAUSE_KEY_EN
    // Pause key freezes gravity and discards keys; second press resumes
    send_byte(8'h4D);
    check("pause_on", paused, 1);
    send_byte(8'h1C);
    @(negedge Clock);
    check("pause_discard_q", q_count, 0);
    wait_hs(40, op, at, ok);
    check("pause_no_issue", ok, 0);
    send_byte(8'h4D);
    check("pause_off", paused, 0);
    wait_hs(40, op, at, ok);
    check("pause_resume_op", op, E_GRAV);
`else
    // Without the pause feature 4D is just an unmapped byte
    send_byte(8'h4D);
    repeat (2) @(negedge Clock);
    check("p_unmapped_paused", paused,  0);
    check("p_unmapped_q",      q_count, 0);
`endif

    // Asynchronous reset mid-operation
    cmd_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h23);
    @(negedge Clock);
    check("ar_pre_valid", cmd_valid, 1);
    check("ar_pre_q",     q_count,   1);
    #2;
    Resetn = 1'b0;
    #1;
    check("ar_valid",    cmd_valid, 0);
    check("ar_op",       cmd_op,    0);
    check("ar_q_count",  q_count,   0);
    check("ar_overflow", overflow,  0);
    check("ar_paused",   paused,    0);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (4) @(negedge Clock);
    check("ar_cmd_lost", cmd_valid, 0);
    check("ar_q_after",  q_count,   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
